mmio_uart_tx: RTL

Memory-mapped serial transmit peripheral that sits directly downstream of the computer top. It snoops the memwrite/dataadr/writedata store bus the computer emits. Stores to its address window push bytes into a small FIFO, which an 8N1 serializer drains onto a single tx line. It also returns a status word for the loads the cpu issues to the same window.

---
 rtl/mmio_uart_tx_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/mmio_uart_tx.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register window layout, STATUS bit positions and serializer states.
package mmio_uart_tx_pkg;

  localparam logic [31:0] UART_BASE_ADDR  = 32'hFFFF_FF00;
  localparam logic [31:0] UART_TXDATA_OFS = 32'd0;
  localparam logic [31:0] UART_STATUS_OFS = 32'd4;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_BUSY_BIT  = 2;
  localparam int STATUS_OVF_BIT   = 3;
  localparam int STATUS_CNT_LSB   = 4;
  localparam int STATUS_CNT_MSB   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count.
// Head is visible combinationally on dout; push/pop take effect at the edge.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // Storage array: written on accepted pushes only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the cpu store bus.
// Store at edge k shows up as tx start bit after edge k+1; a frame is 10*CLKS_PER_BIT cycles.
// No backpressure on the bus: stores to a full FIFO are dropped and flagged in sticky overflow.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int            n            = 32,
  parameter logic [n-1:0]  BASE_ADDR    = n'(UART_BASE_ADDR),
  parameter int            CLKS_PER_BIT = 16,
  parameter int            FIFO_DEPTH   = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [n-1:0] dataadr,
  input  logic [n-1:0] writedata,
  output logic         sel,
  output logic [n-1:0] rdata,
  output logic         tx,
  output logic         busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  uart_tx_state_t state;
  logic [BW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           overflow;

  logic           txdata_hit;
  logic           status_hit;
  logic           push;
  logic           pop;
  logic           ovf_set;
  logic           ovf_clr;
  logic           baud_last;
  logic [7:0]     fifo_dout;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic [3:0]     count_sat;
  logic [n-1:0]   status;
  logic           unused_wdata;

  // Full-width decode: misaligned offsets inside the window never select.
  assign txdata_hit = (dataadr == BASE_ADDR + n'(UART_TXDATA_OFS));
  assign status_hit = (dataadr == BASE_ADDR + n'(UART_STATUS_OFS));
  assign sel        = txdata_hit || status_hit;

  assign push      = memwrite && txdata_hit;
  assign pop       = (state == IDLE) && !fifo_empty;
  assign ovf_set   = push && fifo_full && !pop;
  assign ovf_clr   = memwrite && status_hit && writedata[STATUS_OVF_BIT];
  assign baud_last = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  assign busy      = (state != IDLE);
  assign count_sat = (32'(fifo_count) > 32'd15) ? 4'hF : 4'(fifo_count);

  assign unused_wdata = ^{writedata[n-1:8]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (writedata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Assemble the STATUS word; TXDATA and everything outside the window read as zero.
  always_comb begin
    status = '0;
    status[STATUS_FULL_BIT]                = fifo_full;
    status[STATUS_EMPTY_BIT]               = fifo_empty;
    status[STATUS_BUSY_BIT]                = busy;
    status[STATUS_OVF_BIT]                 = overflow;
    status[STATUS_CNT_MSB:STATUS_CNT_LSB]  = count_sat;
    rdata = status_hit ? status : '0;
  end

  // Sticky overflow: a dropped byte in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (!reset)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  // Serializer: tx is registered and always set to the level of the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            shift    <= fifo_dout;
            baud_cnt <= '0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
